// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchronised, oversampled serial input sampled at mid-bit,
// start-bit glitch rejection, parity/framing/overrun flags and a valid/ready holding register.
module uart_rx_param #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 stream,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned        IDX_W      = $clog2(DATA_BITS);
  localparam logic [15:0]        HALF_CNT   = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0]        FULL_CNT   = 16'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(DATA_BITS - 1);
  localparam logic               LAST_STOP  = (STOP_BITS == 2);
  localparam logic               ODD_PARITY = (PARITY == 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [15:0]            baud_cnt;
  logic [IDX_W-1:0]       bit_idx;
  logic                   stop_idx;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   par_q;
  logic                   ferr_acc;
  logic                   at_half;
  logic                   at_full;
  logic                   cnt_clr;
  logic                   frame_start;
  logic                   samp_data;
  logic                   samp_par;
  logic                   samp_stop;
  logic                   frame_done;
  logic                   ferr_final;
  logic                   perr_final;
  logic                   accept;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync_q <= '1;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], stream};
  end

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign at_half = (baud_cnt == HALF_CNT);
  assign at_full = (baud_cnt == FULL_CNT);

  // The final stop sample is folded in combinationally so the frame completes on that cycle.
  assign ferr_final = ferr_acc | ~rx_s;
  assign perr_final = (PARITY != 0) && ((^shift_q ^ par_q) != ODD_PARITY);
  assign frame_done = samp_stop && (stop_idx == LAST_STOP);
  assign accept     = frame_done && (!valid || ready);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (!rx_s) state_next = ST_START;
      ST_START:  if (at_half) state_next = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:   if (at_full && bit_idx == LAST_IDX)
                   state_next = (PARITY != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (at_full) state_next = ST_STOP;
      ST_STOP:   if (frame_done)
                   state_next = (ferr_final && shift_q == '0) ? ST_BREAK : ST_IDLE;
      ST_BREAK:  if (rx_s) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = 1'b1;
    cnt_clr     = 1'b0;
    frame_start = 1'b0;
    samp_data   = 1'b0;
    samp_par    = 1'b0;
    samp_stop   = 1'b0;
    case (state)
      ST_IDLE: begin
        busy        = 1'b0;
        cnt_clr     = 1'b1;
        frame_start = !rx_s;
      end
      ST_START:  cnt_clr = at_half;
      ST_DATA: begin
        cnt_clr   = at_full;
        samp_data = at_full;
      end
      ST_PARITY: begin
        cnt_clr  = at_full;
        samp_par = at_full;
      end
      ST_STOP: begin
        cnt_clr   = at_full;
        samp_stop = at_full;
      end
      ST_BREAK:  cnt_clr = 1'b1;
      default: begin
        busy    = 1'b0;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      ferr_acc <= 1'b0;
    end else begin
      baud_cnt <= cnt_clr ? '0 : baud_cnt + 16'd1;
      if (frame_start) begin
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        shift_q  <= '0;
        par_q    <= 1'b0;
        ferr_acc <= 1'b0;
      end
      if (samp_data) begin
        shift_q[bit_idx] <= rx_s;
        bit_idx          <= (bit_idx == LAST_IDX) ? '0 : bit_idx + IDX_W'(1);
      end
      if (samp_par) par_q <= rx_s;
      if (samp_stop) begin
        if (!rx_s) ferr_acc <= 1'b1;
        stop_idx <= frame_done ? 1'b0 : ~stop_idx;
      end
    end
  end

  // Holding register: a completed frame is taken only if the slot is free or being emptied now.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= frame_done && !accept;
      if (accept) begin
        data       <= shift_q;
        parity_err <= perr_final;
        frame_err  <= ferr_final;
        valid      <= 1'b1;
      end else if (valid && ready) begin
        valid      <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 instance and a 7E2 instance driven by a bit-level serial
// model, with expected words queued at transmit time and matched against delivered words.
module tb_uart_rx_param;

  localparam int CLKS = 16;
  localparam int SYNC = 2;

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    int         cyc;
  } word_t;

  logic       clock    = 1'b0;
  logic       reset_n  = 1'b1;
  logic       stream_a = 1'b1;
  logic       stream_b = 1'b1;
  logic       ready_a  = 1'b1;
  logic       ready_b  = 1'b1;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic       valid_a, valid_b, perr_a, perr_b, ferr_a, ferr_b;
  logic       ovr_a, ovr_b, busy_a, busy_b;

  int    cyc       = 0;
  int    checks    = 0;
  int    passed    = 0;
  int    ovr_cnt_a = 0;
  int    ovr_cyc_a = -1;
  int    ovr_cnt_b = 0;
  word_t exp_a[$], exp_b[$], got_a[$], got_b[$];

  uart_rx_param #(
    .CLKS_PER_BIT(CLKS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(SYNC)
  ) dut_a (
    .clock(clock), .reset_n(reset_n), .stream(stream_a), .data(data_a), .valid(valid_a),
    .ready(ready_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a), .busy(busy_a)
  );

  uart_rx_param #(
    .CLKS_PER_BIT(CLKS), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .SYNC_STAGES(SYNC)
  ) dut_b (
    .clock(clock), .reset_n(reset_n), .stream(stream_b), .data(data_b), .valid(valid_b),
    .ready(ready_b), .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b), .busy(busy_b)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (valid_a && ready_a) got_a.push_back('{{1'b0, data_a}, perr_a, ferr_a, cyc});
    if (valid_b && ready_b) got_b.push_back('{{2'b0, data_b}, perr_b, ferr_b, cyc});
    if (ovr_a) begin
      ovr_cnt_a++;
      ovr_cyc_a = cyc;
    end
    if (ovr_b) ovr_cnt_b++;
  end

  task automatic drive_bit(input bit b, input logic v);
    if (b) stream_b = v;
    else   stream_a = v;
    repeat (CLKS) @(posedge clock);
    #1;
  endtask

  // Valid is expected SYNC + CLKS*(1.5 + D + P + S - 1) + 1 clocks after the start edge.
  task automatic send_frame(input bit b, input logic [8:0] word, input bit flip,
                            input bit stop_low, input bit push, input bit chk_cyc);
    int         nbits, stops, pm, flen, f;
    logic [8:0] w;
    logic       par;
    word_t      e;
    nbits  = b ? 7 : 8;
    stops  = b ? 2 : 1;
    pm     = b ? 2 : 0;
    flen   = 1 + nbits + ((pm != 0) ? 1 : 0) + stops;
    w      = word & (b ? 9'h07F : 9'h0FF);
    par    = (^w) ^ (pm == 1) ^ flip;
    f      = cyc;
    e.data = w;
    e.perr = flip && (pm != 0);
    e.ferr = stop_low;
    e.cyc  = chk_cyc ? f + SYNC + CLKS * (flen - 1) + CLKS / 2 + 1 : -1;
    if (push) begin
      if (b) exp_b.push_back(e);
      else   exp_a.push_back(e);
    end
    drive_bit(b, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(b, w[i]);
    if (pm != 0) drive_bit(b, par);
    for (int s = 0; s < stops; s++) drive_bit(b, !(stop_low && s == 0));
    if (b) stream_b = 1'b1;
    else   stream_a = 1'b1;
  endtask

  task automatic wait_got(input bit b, input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ((b ? got_b.size() : got_a.size()) >= n) begin
        ok = 1'b1;
        break;
      end
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset();
    word_t e, g;
    bit    ok;
    #2;
    checks++;
    if ({valid_a, data_a, perr_a, ferr_a, ovr_a, busy_a} !== 13'd0)
      $display("FAIL reset_initial: got %b expected all 0", {valid_a, data_a, perr_a, ferr_a, ovr_a, busy_a});
    else passed++;
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clock); #1;
    stream_a = 1'b0;
    repeat (40) @(posedge clock); #1;
    checks++;
    if (busy_a !== 1'b1) $display("FAIL reset_midframe_busy: got %b expected 1", busy_a);
    else passed++;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({valid_a, busy_a, ovr_a} !== 3'b000)
      $display("FAIL reset_async_ctrl: got valid/busy/ovr %b expected 000", {valid_a, busy_a, ovr_a});
    else passed++;
    checks++;
    if ({data_a, perr_a, ferr_a} !== 10'd0)
      $display("FAIL reset_async_data: got %h expected 0", {data_a, perr_a, ferr_a});
    else passed++;
    stream_a = 1'b1;
    repeat (3) @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (300) @(posedge clock); #1;
    checks++;
    if (valid_a !== 1'b0 || got_a.size() != 0)
      $display("FAIL reset_no_word: got valid %b words %0d expected 0 0", valid_a, got_a.size());
    else passed++;
    send_frame(0, 9'h0A5, 0, 0, 1, 1);
    wait_got(0, 1, ok);
    checks++;
    if (!ok) $display("FAIL reset_a5_timeout: got 0 words expected 1");
    else passed++;
    while (ok && got_a.size() > 0 && exp_a.size() > 0) begin
      e = exp_a.pop_front();
      g = got_a.pop_front();
      checks++;
      if (g.data !== e.data) $display("FAIL reset_a5_data: got %h expected %h", g.data, e.data);
      else passed++;
      checks++;
      if ({g.perr, g.ferr} !== {e.perr, e.ferr})
        $display("FAIL reset_a5_flags: got %b expected %b", {g.perr, g.ferr}, {e.perr, e.ferr});
      else passed++;
      checks++;
      if (g.cyc != e.cyc) $display("FAIL reset_a5_latency: got cycle %0d expected %0d", g.cyc, e.cyc);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    word_t e, g;
    bit    ok;
    ready_a = 1'b1;
    send_frame(0, 9'h055, 0, 0, 1, 1);
    send_frame(0, 9'h0A3, 0, 0, 1, 1);
    wait_got(0, 2, ok);
    repeat (50) @(posedge clock); #1;
    checks++;
    if (!ok || got_a.size() != 2) $display("FAIL b2b_count: got %0d words expected 2", got_a.size());
    else passed++;
    while (got_a.size() > 0 && exp_a.size() > 0) begin
      e = exp_a.pop_front();
      g = got_a.pop_front();
      checks++;
      if (g.data !== e.data) $display("FAIL b2b_data: got %h expected %h", g.data, e.data);
      else passed++;
      checks++;
      if ({g.perr, g.ferr} !== 2'b00) $display("FAIL b2b_flags: got %b expected 00", {g.perr, g.ferr});
      else passed++;
      checks++;
      if (g.cyc != e.cyc) $display("FAIL b2b_latency: got cycle %0d expected %0d", g.cyc, e.cyc);
      else passed++;
    end
  endtask

  task automatic test_parity();
    word_t e, g;
    bit    ok;
    ready_b = 1'b1;
    send_frame(1, 9'h03C, 0, 0, 1, 1);
    send_frame(1, 9'h03C, 1, 0, 1, 1);
    wait_got(1, 2, ok);
    checks++;
    if (!ok) $display("FAIL parity_count: got %0d words expected 2", got_b.size());
    else passed++;
    while (got_b.size() > 0 && exp_b.size() > 0) begin
      e = exp_b.pop_front();
      g = got_b.pop_front();
      checks++;
      if (g.data !== e.data) $display("FAIL parity_data: got %h expected %h", g.data, e.data);
      else passed++;
      checks++;
      if (g.perr !== e.perr) $display("FAIL parity_err: got %b expected %b", g.perr, e.perr);
      else passed++;
      checks++;
      if (g.ferr !== 1'b0) $display("FAIL parity_frame: got %b expected 0", g.ferr);
      else passed++;
      checks++;
      if (g.cyc != e.cyc) $display("FAIL parity_latency: got cycle %0d expected %0d", g.cyc, e.cyc);
      else passed++;
    end
  endtask

  task automatic test_framing_break();
    word_t e, g;
    bit    ok;
    int    f;
    ready_a = 1'b1;
    send_frame(0, 9'h081, 0, 1, 1, 1);
    repeat (2 * CLKS) @(posedge clock); #1;
    f = cyc;
    exp_a.push_back('{9'h000, 1'b0, 1'b1, f + SYNC + CLKS * 9 + CLKS / 2 + 1});
    stream_a = 1'b0;
    repeat (30 * CLKS) @(posedge clock); #1;
    checks++;
    if (busy_a !== 1'b1) $display("FAIL break_busy_low: got %b expected 1", busy_a);
    else passed++;
    stream_a = 1'b1;
    repeat (10) @(posedge clock); #1;
    checks++;
    if (busy_a !== 1'b0) $display("FAIL break_busy_released: got %b expected 0", busy_a);
    else passed++;
    wait_got(0, 2, ok);
    repeat (50) @(posedge clock); #1;
    checks++;
    if (!ok || got_a.size() != 2) $display("FAIL break_count: got %0d words expected 2", got_a.size());
    else passed++;
    while (got_a.size() > 0 && exp_a.size() > 0) begin
      e = exp_a.pop_front();
      g = got_a.pop_front();
      checks++;
      if (g.data !== e.data) $display("FAIL frame_data: got %h expected %h", g.data, e.data);
      else passed++;
      checks++;
      if ({g.perr, g.ferr} !== {e.perr, e.ferr})
        $display("FAIL frame_flags: got %b expected %b", {g.perr, g.ferr}, {e.perr, e.ferr});
      else passed++;
      checks++;
      if (g.cyc != e.cyc) $display("FAIL frame_latency: got cycle %0d expected %0d", g.cyc, e.cyc);
      else passed++;
    end
  endtask

  task automatic test_glitch();
    stream_a = 1'b0;
    repeat (5) @(posedge clock); #1;
    stream_a = 1'b1;
    checks++;
    if (busy_a !== 1'b1) $display("FAIL glitch_entered: got busy %b expected 1", busy_a);
    else passed++;
    repeat (30) @(posedge clock); #1;
    checks++;
    if ({busy_a, valid_a} !== 2'b00 || got_a.size() != 0)
      $display("FAIL glitch_rejected: got busy/valid %b words %0d expected 00 0", {busy_a, valid_a}, got_a.size());
    else passed++;
  endtask

  task automatic test_overrun();
    word_t e, g;
    bit    ok;
    int    f1, base;
    ready_a = 1'b0;
    base    = ovr_cnt_a;
    f1      = cyc;
    send_frame(0, 9'h011, 0, 0, 1, 0);
    send_frame(0, 9'h022, 0, 0, 0, 0);
    repeat (20) @(posedge clock); #1;
    checks++;
    if (valid_a !== 1'b1 || data_a !== 8'h11)
      $display("FAIL ovr_held: got valid %b data %h expected 1 11", valid_a, data_a);
    else passed++;
    checks++;
    if (ovr_cnt_a - base != 1) $display("FAIL ovr_pulse_width: got %0d cycles expected 1", ovr_cnt_a - base);
    else passed++;
    checks++;
    if (ovr_cyc_a != f1 + 10 * CLKS + SYNC + CLKS * 9 + CLKS / 2 + 1)
      $display("FAIL ovr_pulse_time: got cycle %0d expected %0d", ovr_cyc_a,
               f1 + 10 * CLKS + SYNC + CLKS * 9 + CLKS / 2 + 1);
    else passed++;
    ready_a = 1'b1;
    @(posedge clock); #1;
    ready_a = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (valid_a !== 1'b0) $display("FAIL ovr_drain_valid: got %b expected 0", valid_a);
    else passed++;

    base = ovr_cnt_a;
    f1   = cyc;
    fork
      begin
        send_frame(0, 9'h011, 0, 0, 1, 0);
        send_frame(0, 9'h022, 0, 0, 1, 0);
      end
      begin
        while (cyc < f1 + 10 * CLKS + SYNC + CLKS * 9 + CLKS / 2) begin
          @(posedge clock); #1;
        end
        ready_a = 1'b1;
        @(posedge clock); #1;
        ready_a = 1'b0;
      end
    join
    repeat (5) @(posedge clock); #1;
    checks++;
    if (valid_a !== 1'b1 || data_a !== 8'h22)
      $display("FAIL ovr_ready_load: got valid %b data %h expected 1 22", valid_a, data_a);
    else passed++;
    checks++;
    if (ovr_cnt_a != base) $display("FAIL ovr_ready_none: got %0d pulses expected 0", ovr_cnt_a - base);
    else passed++;
    ready_a = 1'b1;
    wait_got(0, 3, ok);
    checks++;
    if (!ok) $display("FAIL ovr_drain_count: got %0d words expected 3", got_a.size());
    else passed++;
    while (got_a.size() > 0 && exp_a.size() > 0) begin
      e = exp_a.pop_front();
      g = got_a.pop_front();
      checks++;
      if (g.data !== e.data || g.ferr !== 1'b0)
        $display("FAIL ovr_word: got %h/%b expected %h/0", g.data, g.ferr, e.data);
      else passed++;
    end
  endtask

  initial begin
    #1 reset_n = 1'b0;
    test_reset();
    test_back_to_back();
    test_parity();
    test_framing_break();
    test_glitch();
    test_overrun();
    repeat (20) @(posedge clock); #1;
    checks++;
    if (exp_a.size() + exp_b.size() + got_a.size() + got_b.size() != 0 || ovr_cnt_b != 0)
      $display("FAIL leftovers: got exp %0d/%0d got %0d/%0d ovr_b %0d expected all 0",
               exp_a.size(), exp_b.size(), got_a.size(), got_b.size(), ovr_cnt_b);
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

endmodule
